// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg
//   Shared constants for the writeback stage: data width, register file
//   geometry, number of result sources and per-source buffer depth.
//   Also holds the round-robin pointer advance helper used by the arbiter.
package writeback_arbiter_pkg;

  localparam int WB_WORD   = 32;  // register data width
  localparam int WB_NREG   = 32;  // architectural registers
  localparam int WB_REG_AW = 5;   // clog2(WB_NREG)
  localparam int WB_NSRC   = 4;   // result sources (functional units)
  localparam int WB_DEPTH  = 2;   // entries per source FIFO, power of two

  // Advance a round-robin index by one, wrapping at n. Works for any n,
  // not just powers of two.
  function automatic int rr_advance(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// wb_fifo
//   Small synchronous FIFO buffering one source's results ahead of the
//   writeback arbiter. Pointers wrap modulo DEPTH; an explicit count gives
//   full/empty. A push while full or a pop while empty is ignored.
// Ports
//   clk    in   1      clock
//   rst    in   1      synchronous reset, active-high (empties the FIFO)
//   push   in   1      write din this cycle
//   pop    in   1      drop the head entry this cycle
//   din    in   WIDTH  entry to write
//   dout   out  WIDTH  current head entry (valid when empty is low)
//   full   out  1      count == DEPTH
//   empty  out  1      count == 0
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int WIDTH = WB_REG_AW + WB_WORD,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Writeback stage in front of the register file's single write port.
//   Each source's results are buffered in its own wb_fifo; every cycle one
//   non-empty FIFO head is chosen round-robin and registered onto the write
//   port, together with a one-hot per-register write enable. Register 0 is
//   hardwired, so a write to it shows wb_valid_o but raises no enable.
// Ports
//   clk          in   1           clock
//   rst          in   1           synchronous reset, active-high
//   res_valid_i  in   N_SRC       source i offers a result
//   res_ready_o  out  N_SRC       source i FIFO can accept (not full)
//   res_addr_i   in   N_SRC*AW    destination register, slice [i*AW +: AW]
//   res_data_i   in   N_SRC*WORD  result data, slice [i*WORD +: WORD]
//   wb_valid_o   out  1           a writeback is presented this cycle
//   wb_addr_o    out  AW          destination register
//   wb_data_o    out  WORD        data to the register cells
//   wb_en_o      out  NREG        one-hot write enable, bit r -> cell r
//   busy_o       out  1           any FIFO non-empty or wb_valid_o high
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int N_SRC = WB_NSRC,
  parameter int WORD  = WB_WORD,
  parameter int NREG  = WB_NREG,
  parameter int AW    = WB_REG_AW,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      res_valid_i,
  output logic [N_SRC-1:0]      res_ready_o,
  input  logic [N_SRC*AW-1:0]   res_addr_i,
  input  logic [N_SRC*WORD-1:0] res_data_i,
  output logic                  wb_valid_o,
  output logic [AW-1:0]         wb_addr_o,
  output logic [WORD-1:0]       wb_data_o,
  output logic [NREG-1:0]       wb_en_o,
  output logic                  busy_o
);

  localparam int RRW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int EW  = AW + WORD;

  logic [N_SRC-1:0] full;
  logic [N_SRC-1:0] empty;
  logic [N_SRC-1:0] grant_vec;
  logic [EW-1:0]    head [N_SRC];
  logic [RRW-1:0]   rr;
  logic [RRW-1:0]   grant_idx;
  logic             grant_any;
  logic [EW-1:0]    grant_entry;
  logic [AW-1:0]    next_addr;
  logic [NREG-1:0]  next_en;

  // Ready depends only on FIFO state, so a FIFO that is full stays not-ready
  // even in a cycle where it is being popped.
  assign res_ready_o = ~full;

  // Everything feeding busy_o is a register, so it reflects post-edge state.
  assign busy_o = (|(~empty)) | wb_valid_o;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    wb_fifo #(
      .WIDTH(EW),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (res_valid_i[i] & ~full[i]),
      .pop  (grant_vec[i]),
      .din  ({res_addr_i[i*AW +: AW], res_data_i[i*WORD +: WORD]}),
      .dout (head[i]),
      .full (full[i]),
      .empty(empty[i])
    );
  end

  // Scan sources starting at the rr pointer; the first non-empty one wins
  // and is popped at the coming edge.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vec = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_SRC) begin
        idx = idx - N_SRC;
      end
      if (!grant_any && !empty[idx]) begin
        grant_any      = 1'b1;
        grant_idx      = RRW'(idx);
        grant_vec[idx] = 1'b1;
      end
    end
  end

  assign grant_entry = head[grant_idx];
  assign next_addr   = grant_entry[EW-1 -: AW];

  // One-hot enable for the granted register; r0 never gets an enable.
  always_comb begin
    next_en = '0;
    if (next_addr != '0) begin
      next_en[next_addr] = 1'b1;
    end
  end

  // Output register and round-robin pointer. Address/data hold their last
  // value on idle cycles; only valid and the enables drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr         <= '0;
      wb_valid_o <= 1'b0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
      wb_en_o    <= '0;
    end else if (grant_any) begin
      rr         <= RRW'(rr_advance(int'(grant_idx), N_SRC));
      wb_valid_o <= 1'b1;
      wb_addr_o  <= next_addr;
      wb_data_o  <= grant_entry[WORD-1:0];
      wb_en_o    <= next_en;
    end else begin
      wb_valid_o <= 1'b0;
      wb_en_o    <= '0;
    end
  end

endmodule
